keyboard_decoder: RTL and testbench
===================================

# keyboard_decoder

Receives the PS/2 keyboard serial stream, decodes scan codes (make, break and E0-extended), and keeps the held-key levels `left`, `right`, `jump` and the latched `start_game` flag. These are the control inputs of the donkey movement block. It sits between the board PS/2 pins and the movement logic, in the 65 MHz VGA clock domain.

## Interface
- `FILTER_LEN`, default 8: number of consecutive equal samples needed before the filtered `ps2_clk` changes level.
- `TIMEOUT_CYCLES`, default 65000: idle `clk` cycles inside a frame before the frame is aborted (about 1 ms at 65 MHz).
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw keyboard clock pin, asynchronous.
- `ps2_data`  in  1  raw keyboard data pin, asynchronous.
- `left`  out  1  high while the left arrow (E0 6B) is held.
- `right`  out  1  high while the right arrow (E0 74) is held.
- `jump`  out  1  high while Space (29) is held.
- `start_game`  out  1  set by an Enter (5A) make code; stays high until reset.
- `code`  out  8  last correctly received byte.
- `code_valid`  out  1  one-cycle pulse when `code` updates.
- `frame_err`  out  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- Both pins pass through a 2-FF synchronizer. The synchronized `ps2_clk` then goes through a FILTER_LEN-sample stability filter. A falling edge of the filtered clock produces a one-cycle `fall` strobe. `ps2_data` is sampled on `fall`.
- Receive FSM:
  - ST_IDLE: on `fall`, if data=0 go to ST_DATA with bit count 0. If data=1, pulse `frame_err` and stay in ST_IDLE.
  - ST_DATA: on each `fall`, shift the bit in, LSB first. After the 8th bit go to ST_PARITY.
  - ST_PARITY: on `fall`, store the parity bit and go to ST_STOP.
  - ST_STOP: on `fall`, the frame is good if stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). A good frame loads `code` and pulses `code_valid`. A bad frame pulses `frame_err`. Either way, return to ST_IDLE.
- Timeout counter: 17 bits, cleared on every `fall` and while in ST_IDLE. When it reaches TIMEOUT_CYCLES in any state other than ST_IDLE, pulse `frame_err`, return to ST_IDLE and clear the prefix flags.
- Decoder, acting on each `code_valid`:
  - E0: set `ext_pend`.
  - F0: set `brk_pend`.
  - Any other byte: act on the key as below, then clear both pending flags.
- Key map:
  - Extended 6B → `left` = !brk_pend.
  - Extended 74 → `right` = !brk_pend.
  - Non-extended 29 → `jump` = !brk_pend.
  - Non-extended 5A make → `start_game` = 1. A 5A break has no effect.
  - Unmapped codes change no output but still clear the prefix flags.
  - A key must match its extended status exactly: 6B without E0 (keypad 4) does not affect `left`.
- Typematic repeats (the same make code received again) leave the flags at 1.
- `left` and `right` may both be high. Arbitration between them is done by the consumer.
- Reset state: all outputs 0, `code` = 00, FSM in ST_IDLE, filter output 1, pending flags 0. Reset takes effect immediately, including in the middle of a frame. After release, the next start bit begins a fresh frame.

## Timing
- Pin-to-filter latency: 2 cycles for the synchronizer plus FILTER_LEN cycles for the filter.
- Stop-bit `fall` in cycle N: `code` and `code_valid` register in cycle N+1.
- `code_valid` in cycle M: `left`, `right`, `jump` and `start_game` update at cycle M+1.
- `code_valid` and `frame_err` are never high in the same cycle.
- The decoder needs no back-pressure. PS/2 bytes are at least about 1 ms apart, far longer than the 2-cycle decode.

## Test plan
- Reset: drive `rst`=0 asynchronously during ST_DATA → all outputs 0 immediately. After release, a clean frame 29 → `code`=29, `jump`=1.
- Arrow keys: frames E0,6B → `left`=1. Then E0,74 → `right`=1 and `left` stays 1. Then E0,F0,6B → `left`=0 and `right` stays 1.
- Extended match: frames 6B (no E0) → `left` stays 0, `code_valid` pulses once. Frame 5A → `start_game`=1. Then F0,5A → `start_game` stays 1.
- Errors: frame 29 with even parity → `frame_err` pulse, `jump` unchanged, no `code_valid`. Frame with stop=0 → same response.
- Timeout: stop toggling `ps2_clk` after 4 data bits for TIMEOUT_CYCLES+1 cycles → one `frame_err` pulse, FSM in ST_IDLE. The next clean frame 29 is decoded correctly.
- Glitch rejection: a low pulse on `ps2_clk` shorter than FILTER_LEN−1 cycles while idle → no start detected, no `frame_err`.

Source files
------------

// File: rtl/keyboard_decoder.sv
// PS/2 keyboard receiver and scan-code decoder producing held-key levels for the donkey movement block.
// Pins are synchronized and the clock is debounced before frames are shifted in and decoded.
module keyboard_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       left,
  output logic       right,
  output logic       jump,
  output logic       start_game,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int            FW        = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [16:0]   TMO       = 17'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic [1:0]    clk_sync_r, data_sync_r;
  logic [FW-1:0] filt_cnt_r;
  logic          filt_r, filt_prev_r;
  logic          fall_s, data_s;

  state_t      state_r, state_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic [7:0]  shift_r, shift_s;
  logic        par_r, par_s;
  logic [16:0] timer_r, timer_s;
  logic [7:0]  code_r, code_s;
  logic        code_valid_r, code_valid_s;
  logic        frame_err_r, frame_err_s;
  logic        timeout_r, timeout_s;

  logic ext_pend_r, ext_pend_s, brk_pend_r, brk_pend_s;
  logic left_r, left_s, right_r, right_s, jump_r, jump_s, start_r, start_s;

  assign data_s = data_sync_r[1];
  assign fall_s = filt_prev_r & ~filt_r;

  // Two-flop synchronizers for both raw pins (idle-high lines reset to 1)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Stability filter: the output follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_cnt_r  <= '0;
      filt_r      <= 1'b1;
      filt_prev_r <= 1'b1;
    end else begin
      filt_prev_r <= filt_r;
      if (clk_sync_r[1] == filt_r) begin
        filt_cnt_r <= '0;
      end else if (filt_cnt_r == FILT_LAST) begin
        filt_r     <= clk_sync_r[1];
        filt_cnt_r <= '0;
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  // Receive FSM next-state logic, including the inter-bit timeout
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    shift_s      = shift_r;
    par_s        = par_r;
    code_s       = code_r;
    code_valid_s = 1'b0;
    frame_err_s  = 1'b0;
    timeout_s    = 1'b0;
    if (fall_s || state_r == ST_IDLE) begin
      timer_s = 17'd0;
    end else begin
      timer_s = timer_r + 17'd1;
    end
    if (fall_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!data_s) begin
            state_s   = ST_DATA;
            bit_cnt_s = 3'd0;
          end else begin
            frame_err_s = 1'b1;
          end
        end
        ST_DATA: begin
          shift_s   = {data_s, shift_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_s = ST_PARITY;
          end else begin
            state_s = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_s   = data_s;
          state_s = ST_STOP;
        end
        ST_STOP: begin
          if (data_s && odd_parity_ok(shift_r, par_r)) begin
            code_s       = shift_r;
            code_valid_s = 1'b1;
          end else begin
            frame_err_s = 1'b1;
          end
          state_s = ST_IDLE;
        end
        default: state_s = ST_IDLE;
      endcase
    end else if (state_r != ST_IDLE && timer_r == TMO) begin
      frame_err_s = 1'b1;
      timeout_s   = 1'b1;
      state_s     = ST_IDLE;
      timer_s     = 17'd0;
    end else begin
      state_s = state_r;
    end
  end

  // Receive FSM state and registered frame outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      par_r        <= 1'b0;
      timer_r      <= 17'd0;
      code_r       <= 8'h00;
      code_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      bit_cnt_r    <= bit_cnt_s;
      shift_r      <= shift_s;
      par_r        <= par_s;
      timer_r      <= timer_s;
      code_r       <= code_s;
      code_valid_r <= code_valid_s;
      frame_err_r  <= frame_err_s;
      timeout_r    <= timeout_s;
    end
  end

  // Scan-code decoder: prefixes arm pending flags, the next byte consumes them
  always_comb begin
    ext_pend_s = ext_pend_r;
    brk_pend_s = brk_pend_r;
    left_s     = left_r;
    right_s    = right_r;
    jump_s     = jump_r;
    start_s    = start_r;
    if (timeout_r) begin
      ext_pend_s = 1'b0;
      brk_pend_s = 1'b0;
    end else if (code_valid_r) begin
      case (code_r)
        8'hE0: ext_pend_s = 1'b1;
        8'hF0: brk_pend_s = 1'b1;
        default: begin
          if (ext_pend_r && code_r == 8'h6B) begin
            left_s = ~brk_pend_r;
          end else if (ext_pend_r && code_r == 8'h74) begin
            right_s = ~brk_pend_r;
          end else if (!ext_pend_r && code_r == 8'h29) begin
            jump_s = ~brk_pend_r;
          end else if (!ext_pend_r && !brk_pend_r && code_r == 8'h5A) begin
            start_s = 1'b1;
          end else begin
            start_s = start_r;
          end
          ext_pend_s = 1'b0;
          brk_pend_s = 1'b0;
        end
      endcase
    end else begin
      ext_pend_s = ext_pend_r;
    end
  end

  // Decoder registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_pend_r <= 1'b0;
      brk_pend_r <= 1'b0;
      left_r     <= 1'b0;
      right_r    <= 1'b0;
      jump_r     <= 1'b0;
      start_r    <= 1'b0;
    end else begin
      ext_pend_r <= ext_pend_s;
      brk_pend_r <= brk_pend_s;
      left_r     <= left_s;
      right_r    <= right_s;
      jump_r     <= jump_s;
      start_r    <= start_s;
    end
  end

  assign left       = left_r;
  assign right      = right_r;
  assign jump       = jump_r;
  assign start_game = start_r;
  assign code       = code_r;
  assign code_valid = code_valid_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_keyboard_decoder.sv
// Self-checking bench for keyboard_decoder: serial PS/2 frames in, held-key flags checked
// against a key-level behavioural model.
module tb_keyboard_decoder;
  localparam int FL  = 8;
  localparam int TMO = 500;

  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data;
  logic left, right, jump, start_game, code_valid, frame_err;
  logic [7:0] code;

  keyboard_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .left(left), .right(right), .jump(jump), .start_game(start_game),
    .code(code), .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int cv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int half_r = 16;
  logic m_left, m_right, m_jump, m_start, m_ext, m_brk;
  logic [7:0] m_code;

  // pulse counters for code_valid / frame_err
  always @(negedge clk) begin
    if (code_valid) cv_cnt++;
    if (frame_err) fe_cnt++;
    if (code_valid && frame_err) both_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_left = 1'b0; m_right = 1'b0; m_jump = 1'b0; m_start = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_code = 8'h00;
  endtask

  // byte-level reference: prefixes arm, any other byte resolves the key and clears them
  task automatic model_byte(input logic [7:0] b);
    m_code = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (m_ext && b == 8'h6B) m_left = !m_brk;
      else if (m_ext && b == 8'h74) m_right = !m_brk;
      else if (!m_ext && b == 8'h29) m_jump = !m_brk;
      else if (!m_ext && b == 8'h5A && !m_brk) m_start = 1'b1;
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cycles(half_r);
    ps2_clk = 1'b0;
    cycles(half_r);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    half_r = $urandom_range(12, 24);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    cycles(4 + $urandom_range(0, 20));
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
    model_byte(b);
  endtask

  task automatic test_reset();
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    model_reset();
    cycles(3);
    nvec++;
    if ({left, right, jump, start_game, code, code_valid, frame_err} !== 14'd0) begin
      nerr++; $display("FAIL reset_state: got %b want 0", {left, right, jump, start_game, code, code_valid, frame_err});
    end
    rst = 1'b1;
    cycles(3);
  endtask

  task automatic test_arrows();
    int cv0;
    cv0 = cv_cnt;
    send_byte(8'hE0); send_byte(8'h6B);
    nvec++;
    if ({left, right, jump, start_game} !== {m_left, m_right, m_jump, m_start}) begin
      nerr++; $display("FAIL arrow_left_make: got %b want %b", {left, right, jump, start_game}, {m_left, m_right, m_jump, m_start});
    end
    send_byte(8'hE0); send_byte(8'h74);
    nvec++;
    if ({left, right} !== 2'b11) begin
      nerr++; $display("FAIL arrow_both_held: got %b want 11", {left, right});
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
    nvec++;
    if ({left, right, code} !== {1'b0, 1'b1, 8'h6B}) begin
      nerr++; $display("FAIL arrow_left_break: got %b/%h want 01/6b", {left, right}, code);
    end
    nvec++;
    if (cv_cnt - cv0 !== 7) begin
      nerr++; $display("FAIL arrow_valid_count: got %0d want 7", cv_cnt - cv0);
    end
  endtask

  task automatic test_extended_match();
    int cv0;
    cv0 = cv_cnt;
    send_byte(8'h6B);
    nvec++;
    if ({left, cv_cnt - cv0} !== {1'b0, 32'd1}) begin
      nerr++; $display("FAIL keypad4_no_left: got left=%b valid=%0d want left=0 valid=1", left, cv_cnt - cv0);
    end
    send_byte(8'h5A);
    nvec++;
    if (start_game !== 1'b1) begin
      nerr++; $display("FAIL enter_make: got %b want 1", start_game);
    end
    send_byte(8'hF0); send_byte(8'h5A);
    nvec++;
    if ({left, right, jump, start_game} !== {m_left, m_right, m_jump, m_start}) begin
      nerr++; $display("FAIL enter_break_sticky: got %b want %b", {left, right, jump, start_game}, {m_left, m_right, m_jump, m_start});
    end
  endtask

  task automatic test_errors();
    int cv0, fe0;
    send_byte(8'h29);
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h29, 1'b1, 1'b1);
    nvec++;
    if ({fe_cnt - fe0, cv_cnt - cv0} !== {32'd1, 32'd0}) begin
      nerr++; $display("FAIL parity_err: got err=%0d valid=%0d want 1/0", fe_cnt - fe0, cv_cnt - cv0);
    end
    send_byte(8'hF0);
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h29, 1'b0, 1'b0);
    nvec++;
    if ({fe_cnt - fe0, cv_cnt - cv0} !== {32'd1, 32'd0}) begin
      nerr++; $display("FAIL stop_err: got err=%0d valid=%0d want 1/0", fe_cnt - fe0, cv_cnt - cv0);
    end
    nvec++;
    if ({jump, code} !== {m_jump, m_code}) begin
      nerr++; $display("FAIL err_no_effect: got %b/%h want %b/%h", jump, code, m_jump, m_code);
    end
    fe0 = fe_cnt;
    ps2_bit(1'b1);
    cycles(20);
    nvec++;
    if (fe_cnt - fe0 !== 1) begin
      nerr++; $display("FAIL start_err: got %0d want 1", fe_cnt - fe0);
    end
    // the pending break must still apply to the next key
    send_byte(8'h29);
    nvec++;
    if (jump !== m_jump) begin
      nerr++; $display("FAIL break_after_err: got %b want %b", jump, m_jump);
    end
  endtask

  task automatic test_timeout();
    int cv0, fe0;
    send_byte(8'hE0);
    cv0 = cv_cnt; fe0 = fe_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    cycles(TMO + 50);
    nvec++;
    if ({fe_cnt - fe0, cv_cnt - cv0} !== {32'd1, 32'd0}) begin
      nerr++; $display("FAIL timeout_err: got err=%0d valid=%0d want 1/0", fe_cnt - fe0, cv_cnt - cv0);
    end
    m_ext = 1'b0; m_brk = 1'b0;
    send_byte(8'h6B);
    nvec++;
    if (left !== m_left) begin
      nerr++; $display("FAIL timeout_clears_prefix: got left=%b want %b", left, m_left);
    end
    send_byte(8'h29);
    nvec++;
    if ({code, jump} !== {8'h29, 1'b1}) begin
      nerr++; $display("FAIL after_timeout: got %h/%b want 29/1", code, jump);
    end
  endtask

  task automatic test_glitch();
    int cv0, fe0;
    cv0 = cv_cnt; fe0 = fe_cnt;
    for (int w = FL - 4; w <= FL - 2; w++) begin
      ps2_clk = 1'b0; cycles(w); ps2_clk = 1'b1; cycles(30);
    end
    nvec++;
    if ({fe_cnt - fe0, cv_cnt - cv0} !== {32'd0, 32'd0}) begin
      nerr++; $display("FAIL glitch: got err=%0d valid=%0d want 0/0", fe_cnt - fe0, cv_cnt - cv0);
    end
  endtask

  task automatic test_latency();
    int n;
    logic [7:0] b;
    send_byte(8'hF0); send_byte(8'h29);
    b = 8'h29;
    half_r = 16;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b));
    ps2_data = 1'b1;
    cycles(half_r);
    ps2_clk = 1'b0;
    n = 0;
    for (int k = 1; k <= 30 && n == 0; k++) begin
      cycles(1);
      if (code_valid) n = k;
    end
    nvec++;
    if (n < FL + 3 || n > FL + 4) begin
      nerr++; $display("FAIL valid_latency: got %0d cycles want %0d..%0d", n, FL + 3, FL + 4);
    end
    nvec++;
    if ({code, jump} !== {8'h29, 1'b0}) begin
      nerr++; $display("FAIL flags_not_yet: got %h/%b want 29/0", code, jump);
    end
    cycles(1);
    nvec++;
    if ({jump, code_valid} !== 2'b10) begin
      nerr++; $display("FAIL flags_next_cycle: got jump=%b valid=%b want 1/0", jump, code_valid);
    end
    cycles(half_r);
    ps2_clk = 1'b1;
    cycles(10);
    model_byte(8'h29);
  endtask

  task automatic test_reset_midframe();
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    ps2_clk = 1'b0;
    cycles(3);
    #2 rst = 1'b0;
    #1;
    nvec++;
    if ({left, right, jump, start_game, code, code_valid, frame_err} !== 14'd0) begin
      nerr++; $display("FAIL reset_midframe: got %b want 0", {left, right, jump, start_game, code, code_valid, frame_err});
    end
    ps2_clk = 1'b1; ps2_data = 1'b1;
    cycles(5);
    rst = 1'b1;
    model_reset();
    cycles(5);
    send_byte(8'h29);
    nvec++;
    if ({code, left, right, jump, start_game} !== {8'h29, 4'b0010}) begin
      nerr++; $display("FAIL after_reset_frame: got %h/%b want 29/0010", code, {left, right, jump, start_game});
    end
  endtask

  // key-level random sequences: each key is (extended?, code), action make or break
  task automatic test_random();
    logic [7:0] kc [7] = '{8'h6B, 8'h74, 8'h29, 8'h5A, 8'h6B, 8'h1C, 8'h75};
    logic       ke [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int k, cv0, nb;
    logic mk;
    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(0, 6);
      mk = 1'($urandom_range(0, 1));
      cv0 = cv_cnt; nb = 1;
      if (ke[k]) begin send_frame(8'hE0, 1'b0, 1'b1); nb++; end
      if (!mk) begin send_frame(8'hF0, 1'b0, 1'b1); nb++; end
      send_frame(kc[k], 1'b0, 1'b1);
      case (k)
        0: m_left = mk;
        1: m_right = mk;
        2: m_jump = mk;
        3: if (mk) m_start = 1'b1;
        default: ;
      endcase
      m_code = kc[k];
      nvec++;
      if ({left, right, jump, start_game, code, cv_cnt - cv0} !== {m_left, m_right, m_jump, m_start, m_code, nb}) begin
        nerr++; $display("FAIL random_key%0d_mk%0d: got %b/%h/%0d want %b/%h/%0d", k, mk,
          {left, right, jump, start_game}, code, cv_cnt - cv0, {m_left, m_right, m_jump, m_start}, m_code, nb);
      end
    end
  endtask

  task automatic test_no_overlap();
    nvec++;
    if (both_cnt !== 0) begin
      nerr++; $display("FAIL valid_err_overlap: got %0d want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_arrows();
    test_extended_match();
    test_errors();
    test_timeout();
    test_glitch();
    test_latency();
    test_reset_midframe();
    test_random();
    test_no_overlap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
